// File: rtl/sm3_msg_expand_if.sv
// sm3_msg_expand_if: block-in and word-pair-out handshakes of the SM3 expander.
// slave = expansion engine, master = surrounding pipeline (buffer + compressor).
interface sm3_msg_expand_if;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_data;
   logic         w_valid;
   logic         w_ready;
   logic [31:0]  w_j;
   logic [31:0]  wp_j;
   logic [5:0]   w_idx;
   logic         w_last;

   modport slave (
      input  blk_valid, blk_data, w_ready,
      output blk_ready, w_valid, w_j, wp_j, w_idx, w_last
   );

   modport master (
      output blk_valid, blk_data, w_ready,
      input  blk_ready, w_valid, w_j, wp_j, w_idx, w_last
   );
endinterface

// File: rtl/sm3_msg_expand.sv
// sm3_msg_expand: streams the 64 SM3 (W_j, W'_j) pairs of one 512-bit block.
// Define SM3_EXP_BACK2BACK_EN to let the next block load on the j=63 beat.
module sm3_msg_expand (
   input  logic            clk,
   input  logic            rst_n,
   sm3_msg_expand_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

   state_e            state_q, state_d;
   logic [15:0][31:0] win_q, win_d;
   logic [31:0]       wp_q, wp_d;
   logic [5:0]        idx_q, idx_d;
   logic              load, fire, at_end;
   logic [31:0]       w_new;

   function automatic logic [31:0] p1(input logic [31:0] x);
      return x ^ {x[16:0], x[31:17]} ^ {x[8:0], x[31:9]};
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         win_q   <= '0;
         wp_q    <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         wp_q    <= wp_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (load) state_d = RUN;
         RUN:  if (fire && at_end && !load) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.w_valid   = (state_q == RUN);
      bus.blk_ready = (state_q == IDLE);
`ifdef SM3_EXP_BACK2BACK_EN
      if (state_q == RUN) bus.blk_ready = at_end && bus.w_ready;
`endif
      bus.w_j    = win_q[0];
      bus.wp_j   = wp_q;
      bus.w_idx  = idx_q;
      bus.w_last = (state_q == RUN) && at_end;
   end

   // window holds W_j..W_(j+15); W'_j is registered from the next window
   always_comb begin
      at_end = (idx_q == 6'd63);
      load   = bus.blk_valid && bus.blk_ready;
      fire   = (state_q == RUN) && bus.w_ready;
      w_new  = p1(win_q[0] ^ win_q[7] ^ {win_q[13][16:0], win_q[13][31:17]})
             ^ {win_q[3][24:0], win_q[3][31:25]} ^ win_q[10];
      win_d  = win_q;
      idx_d  = idx_q;
      if (load) begin
         for (int i = 0; i < 16; i++) win_d[i] = bus.blk_data[511 - 32*i -: 32];
         idx_d = '0;
      end else if (fire) begin
         win_d = {w_new, win_q[15:1]};
         idx_d = idx_q + 6'd1;
      end
      wp_d = win_d[0] ^ win_d[4];
   end

endmodule
